// File: rtl/des_key_sched_seq.sv
// Sequential DES key schedule: one subkey per handshake, K1..K16 (encrypt) or K16..K1 (decrypt).
// The 28-bit C/D halves are rotated in place; a single PC2 network drives round_key.

module des_pc1 (
  input  logic [63:0] key_i,
  output logic [27:0] c_o,
  output logic [27:0] d_o
);
  // Standard DES numbering: bit 1 is key_i[63]
  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  logic unused_parity_s;
  assign unused_parity_s = ^{key_i[56], key_i[48], key_i[40], key_i[32],
                             key_i[24], key_i[16], key_i[8],  key_i[0]};

  for (genvar g = 0; g < 28; g++) begin : g_pc1
    assign c_o[27-g] = key_i[64-PC1_T[g]];
    assign d_o[27-g] = key_i[64-PC1_T[g+28]];
  end
endmodule

module des_pc2 (
  input  logic [55:0] cd_i,
  output logic [47:0] key_o
);
  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  logic unused_dropped_s;
  assign unused_dropped_s = ^{cd_i[47], cd_i[38], cd_i[34], cd_i[31],
                              cd_i[21], cd_i[18], cd_i[13], cd_i[2]};

  for (genvar g = 0; g < 48; g++) begin : g_pc2
    assign key_o[47-g] = cd_i[56-PC2_T[g]];
  end
endmodule

module des_key_sched_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] key_in,
  input  logic        decrypt,
  input  logic        abort,
  input  logic        key_ready,
  output logic        key_valid,
  output logic [47:0] round_key,
  output logic [3:0]  round_cnt,
  output logic        busy,
  output logic        done
);
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_FIN   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [27:0] c_q, c_d;
  logic [27:0] dh_q, dh_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        dec_q, dec_d;
  logic        valid_q, valid_d;
  logic        done_q, done_d;

  logic [27:0] pc1_c_s, pc1_d_s;
  logic [3:0]  cnt_nxt_s;
  logic        rot_two_s;
  logic        hs_s;

  function automatic logic [27:0] rot28(input logic [27:0] x, input logic right, input logic two);
    logic [27:0] r;
    if (right) begin
      r = two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    end else begin
      r = two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    end
    return r;
  endfunction

  des_pc1 u_pc1 (.key_i(key_in), .c_o(pc1_c_s), .d_o(pc1_d_s));
  des_pc2 u_pc2 (.cd_i({c_q, dh_q}), .key_o(round_key));

  assign hs_s      = valid_q & key_ready;
  assign cnt_nxt_s = cnt_q + 4'd1;
  // Steps 1, 8 and 15 of the issue sequence rotate by one; all others by two
  assign rot_two_s = !((cnt_nxt_s == 4'd1) || (cnt_nxt_s == 4'd8) || (cnt_nxt_s == 4'd15));

  // Next-state logic: abort overrides everything, including a same-cycle handshake
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    dh_d    = dh_q;
    cnt_d   = cnt_q;
    dec_d   = dec_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
      cnt_d   = 4'd0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_ISSUE;
            c_d     = decrypt ? pc1_c_s : rot28(pc1_c_s, 1'b0, 1'b0);
            dh_d    = decrypt ? pc1_d_s : rot28(pc1_d_s, 1'b0, 1'b0);
            cnt_d   = 4'd0;
            dec_d   = decrypt;
            valid_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_ISSUE: begin
          if (hs_s && (cnt_q == 4'd15)) begin
            state_d = ST_FIN;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else if (hs_s) begin
            cnt_d = cnt_nxt_s;
            c_d   = rot28(c_q, dec_q, rot_two_s);
            dh_d  = rot28(dh_q, dec_q, rot_two_s);
          end else begin
            state_d = ST_ISSUE;
          end
        end
        ST_FIN: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      c_q     <= 28'd0;
      dh_q    <= 28'd0;
      cnt_q   <= 4'd0;
      dec_q   <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      dh_q    <= dh_d;
      cnt_q   <= cnt_d;
      dec_q   <= dec_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign key_valid = valid_q;
  assign round_cnt = cnt_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
endmodule

// File: tb/tb_des_key_sched_seq.sv
// Randomized scoreboard bench for des_key_sched_seq against a textbook DES key-schedule model.
module tb_des_key_sched_seq;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [63:0] key_in;
  logic        decrypt;
  logic        abort;
  logic        key_ready;
  logic        key_valid;
  logic [47:0] round_key;
  logic [3:0]  round_cnt;
  logic        busy;
  logic        done;

  des_key_sched_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in), .decrypt(decrypt),
    .abort(abort), .key_ready(key_ready), .key_valid(key_valid), .round_key(round_key),
    .round_cnt(round_cnt), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] key;
    logic [3:0]  cnt;
  } exp_t;

  exp_t        exp_q[$];
  logic [47:0] ks_arr [16];
  int          total = 0;
  int          bad = 0;
  int          done_seen = 0;

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [27:0] rotl(input logic [27:0] x, input int n);
    logic [27:0] r;
    r = (x << n) | (x >> (28 - n));
    return r;
  endfunction

  // Textbook schedule: C_i,D_i by cumulative left shifts, K_i = PC2(C_i,D_i)
  task automatic build_ks(input logic [63:0] key);
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [47:0] k;
    cd = '0;
    for (int i = 0; i < 56; i++) cd = (cd << 1) | 56'((key >> (64 - PC1_T[i])) & 64'd1);
    c = cd[55:28];
    d = cd[27:0];
    for (int r = 0; r < 16; r++) begin
      c = rotl(c, SHIFTS[r]);
      d = rotl(d, SHIFTS[r]);
      k = '0;
      for (int i = 0; i < 48; i++) k = (k << 1) | 48'(({c, d} >> (56 - PC2_T[i])) & 56'd1);
      ks_arr[r] = k;
    end
  endtask

  // Monitor: pops the scoreboard on each handshake and checks stall stability
  initial begin
    exp_t        e;
    bit          stalled = 1'b0;
    logic [47:0] hold_key = '0;
    logic [3:0]  hold_cnt = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled = 1'b0;
      end else begin
        if (key_valid && stalled) begin
          chk("stall_key", round_key, hold_key);
          chk("stall_cnt", round_cnt, hold_cnt);
        end
        if (key_valid && key_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious_key: got cnt %0d key %0h expected no handshake", round_cnt, round_key);
          end else begin
            e = exp_q.pop_front();
            chk("round_key", round_key, e.key);
            chk("round_cnt", round_cnt, e.cnt);
          end
        end
        stalled  = key_valid && !key_ready;
        hold_key = round_key;
        hold_cnt = round_cnt;
        if (done) done_seen++;
      end
    end
  end

  task automatic run_seq(input logic [63:0] key, input logic dec, input bit rnd_ready,
                         input bit glitch, input int abort_at, input int rst_at,
                         input bit chk_fl, input logic [47:0] k_first, input logic [47:0] k_last);
    int   k = 0;
    bit   fin = 1'b0;
    bit   cut = 1'b0;
    bit   last_seen = 1'b0;
    int   done_before;
    exp_t e;
    build_ks(key);
    for (int j = 0; j < 16; j++) begin
      e.key = dec ? ks_arr[15-j] : ks_arr[j];
      e.cnt = 4'(j);
      exp_q.push_back(e);
    end
    done_before = done_seen;
    key_in = key; decrypt = dec; start = 1'b1; key_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; key_in = {$urandom, $urandom}; decrypt = ~dec;
    chk("latency_valid", key_valid, 1);
    chk("start_cnt", round_cnt, 0);
    chk("start_busy", busy, 1);
    if (chk_fl) chk("first_key", round_key, k_first);
    while (!fin && !cut && k < 300) begin
      if (done) begin
        fin = 1'b1;
      end else begin
        if (chk_fl && key_valid && round_cnt == 4'd15 && !last_seen) begin
          chk("last_key", round_key, k_last);
          last_seen = 1'b1;
        end
        key_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        key_in    = {$urandom, $urandom};
        decrypt   = 1'($urandom_range(0, 1));
        start     = glitch && key_valid && (round_cnt == 4'd5 || (round_cnt == 4'd15 && key_ready));
        if (abort_at >= 0 && key_valid && round_cnt == 4'(abort_at)) begin
          abort = 1'b1;
          @(posedge clk); #1;
          abort = 1'b0; key_ready = 1'b0;
          chk("abort_valid", key_valid, 0);
          chk("abort_busy", busy, 0);
          chk("abort_cnt", round_cnt, 0);
          cut = 1'b1;
        end else if (rst_at >= 0 && key_valid && round_cnt == 4'(rst_at)) begin
          key_ready = 1'b0;
          #2 rst_n = 1'b0;
          #1;
          chk("rst_valid", key_valid, 0);
          chk("rst_key", round_key, 0);
          chk("rst_cnt", round_cnt, 0);
          chk("rst_busy", busy, 0);
          chk("rst_done", done, 0);
          exp_q.delete();
          @(posedge clk); #3;
          rst_n = 1'b1;
          cut = 1'b1;
        end else begin
          @(posedge clk); #1;
          k++;
        end
      end
    end
    if (fin) begin
      if (chk_fl) chk("done_latency", k, 16);
      chk("fin_valid", key_valid, 0);
      chk("fin_busy", busy, 1);
      start = glitch; key_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; key_ready = 1'b0;
      chk("idle_busy", busy, 0);
      chk("idle_valid", key_valid, 0);
      chk("done_width", done, 0);
      chk("keys_consumed", exp_q.size(), 0);
      chk("done_count", done_seen - done_before, 1);
    end else if (cut) begin
      exp_q.delete();
      chk("no_done", done_seen - done_before, 0);
    end else begin
      total++;
      bad++;
      $display("FAIL timeout: got no done after %0d cycles expected done", k);
      exp_q.delete();
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; key_in = '0; decrypt = 1'b0; abort = 1'b0; key_ready = 1'b0;
    #12;
    chk("reset_valid", key_valid, 0);
    chk("reset_key", round_key, 0);
    chk("reset_cnt", round_cnt, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    run_seq(64'h133457799BBCDFF1, 1'b0, 1'b0, 1'b0, -1, -1, 1'b1, 48'h1B02EFFC7072, 48'hCB3D8B0E17F5);
    run_seq(64'h133457799BBCDFF1, 1'b1, 1'b0, 1'b0, -1, -1, 1'b1, 48'hCB3D8B0E17F5, 48'h1B02EFFC7072);
    run_seq(64'h133457799BBCDFF1, 1'b0, 1'b1, 1'b0, -1, -1, 1'b0, 48'h0, 48'h0);
    run_seq({$urandom, $urandom}, 1'b0, 1'b0, 1'b1, -1, -1, 1'b0, 48'h0, 48'h0);
    run_seq({$urandom, $urandom}, 1'b1, 1'b1, 1'b1, -1, -1, 1'b0, 48'h0, 48'h0);
    run_seq({$urandom, $urandom}, 1'b0, 1'b1, 1'b0, 7, -1, 1'b0, 48'h0, 48'h0);
    run_seq({$urandom, $urandom}, 1'b0, 1'b0, 1'b0, -1, -1, 1'b0, 48'h0, 48'h0);

    // abort together with start in IDLE must not launch a sequence
    start = 1'b1; abort = 1'b1; key_in = {$urandom, $urandom};
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("abort_start_busy", busy, 0);
    chk("abort_start_valid", key_valid, 0);
    @(posedge clk); #1;

    run_seq({$urandom, $urandom}, 1'b1, 1'b1, 1'b0, -1, 9, 1'b0, 48'h0, 48'h0);
    run_seq({$urandom, $urandom}, 1'b0, 1'b0, 1'b0, -1, -1, 1'b0, 48'h0, 48'h0);
    for (int i = 0; i < 6; i++) begin
      run_seq({$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b1, 1'b0, -1, -1, 1'b0, 48'h0, 48'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
